// File: rtl/apb_mig_pkg.sv
// apb_mig_pkg: shared types and constants for the APB to MIG native-UI bridge.
//   - apb_mig_state_e : bridge FSM states
//   - APP_CMD_WRITE / APP_CMD_READ : MIG app_cmd encodings
//   - *_DEF localparams : default widths used by the bridge parameters
//   - apb_addr_t / data_t : default-width APB address and data types
package apb_mig_pkg;

    localparam int APB_ADDR_W_DEF     = 32;
    localparam int APB_DATA_W_DEF     = 32;
    localparam int APP_ADDR_W_DEF     = 28;
    localparam int APP_DATA_W_DEF     = 128;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_CMD,
        RD_WAIT,
        RESP
    } apb_mig_state_e;

    typedef logic [APB_ADDR_W_DEF-1:0] apb_addr_t;
    typedef logic [APB_DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/apb_mig_lane_pack.sv
// apb_mig_lane_pack: combinational lane steering between one APB word and one
// MIG UI word.
//   wdata_i/wstrb_i/wr_lane_i -> wide_data_o (APB word replicated on every lane)
//                                wide_mask_o (all masked except the chosen
//                                lane, which carries ~wstrb_i)
//   wide_rdata_i/rd_lane_i    -> rdata_o (the chosen lane of the UI word)
module apb_mig_lane_pack
    import apb_mig_pkg::*;
#(
    parameter int APB_DATA_W = APB_DATA_W_DEF,
    parameter int APP_DATA_W = APP_DATA_W_DEF,
    parameter int LANE_IDX_W = 2
) (
    input  logic [APB_DATA_W-1:0]   wdata_i,
    input  logic [APB_DATA_W/8-1:0] wstrb_i,
    input  logic [LANE_IDX_W-1:0]   wr_lane_i,
    output logic [APP_DATA_W-1:0]   wide_data_o,
    output logic [APP_DATA_W/8-1:0] wide_mask_o,
    input  logic [APP_DATA_W-1:0]   wide_rdata_i,
    input  logic [LANE_IDX_W-1:0]   rd_lane_i,
    output logic [APB_DATA_W-1:0]   rdata_o
);

    localparam int STRB_W   = APB_DATA_W / 8;
    localparam int LANE_CNT = APP_DATA_W / APB_DATA_W;

    always_comb begin
        wide_data_o = {LANE_CNT{wdata_i}};
        wide_mask_o = '1;
        rdata_o     = '0;
        for (int i = 0; i < LANE_CNT; i++) begin
            if (wr_lane_i == LANE_IDX_W'(i)) begin
                wide_mask_o[i*STRB_W +: STRB_W] = ~wstrb_i;
            end
            if (rd_lane_i == LANE_IDX_W'(i)) begin
                rdata_o = wide_rdata_i[i*APB_DATA_W +: APB_DATA_W];
            end
        end
    end

endmodule

// File: rtl/apb_mig_bridge.sv
// apb_mig_bridge: APB slave turning single APB transfers into MIG native-UI
// command / write-data / read-data handshakes.
//   APB side : pclk_i, preset_i (sync, active-high), paddr_i, pwdata_i,
//              pwrite_i, psel_i, penable_i, pstrb_i -> prdata_o, pready_o,
//              pslverr_o
//   MIG side : app_init_calib_complete_i, app_rdy_i, app_wdf_rdy_i,
//              app_rd_data_i, app_rd_data_valid_i -> app_addr_o, app_cmd_o,
//              app_en_o, app_wdf_data_o, app_wdf_mask_o, app_wdf_wren_o,
//              app_wdf_end_o
// Optional: define APB_MIG_TIMEOUT_EN to bound every UI wait to TIMEOUT_CYCLES
// cycles, after which the transfer ends with pslverr_o=1.
module apb_mig_bridge
    import apb_mig_pkg::*;
#(
    parameter int APB_ADDR_W     = APB_ADDR_W_DEF,
    parameter int APB_DATA_W     = APB_DATA_W_DEF,
    parameter int APP_ADDR_W     = APP_ADDR_W_DEF,
    parameter int APP_DATA_W     = APP_DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                    pclk_i,
    input  logic                    preset_i,
    input  logic [APB_ADDR_W-1:0]   paddr_i,
    input  logic [APB_DATA_W-1:0]   pwdata_i,
    input  logic                    pwrite_i,
    input  logic                    psel_i,
    input  logic                    penable_i,
    input  logic [APB_DATA_W/8-1:0] pstrb_i,
    output logic [APB_DATA_W-1:0]   prdata_o,
    output logic                    pready_o,
    output logic                    pslverr_o,
    input  logic                    app_init_calib_complete_i,
    output logic [APP_ADDR_W-1:0]   app_addr_o,
    output logic [2:0]              app_cmd_o,
    output logic                    app_en_o,
    input  logic                    app_rdy_i,
    output logic [APP_DATA_W-1:0]   app_wdf_data_o,
    output logic [APP_DATA_W/8-1:0] app_wdf_mask_o,
    output logic                    app_wdf_wren_o,
    output logic                    app_wdf_end_o,
    input  logic                    app_wdf_rdy_i,
    input  logic [APP_DATA_W-1:0]   app_rd_data_i,
    input  logic                    app_rd_data_valid_i
);

    localparam int STRB_W     = APB_DATA_W / 8;
    localparam int OFF_W      = $clog2(STRB_W);
    localparam int LANE_CNT   = APP_DATA_W / APB_DATA_W;
    localparam int LANE_W     = $clog2(LANE_CNT);
    localparam int LANE_IDX_W = (LANE_W > 0) ? LANE_W : 1;
    localparam int LOW_W      = OFF_W + LANE_W;
    localparam logic [APP_ADDR_W-1:0] LOW_MASK = APP_ADDR_W'((1 << LOW_W) - 1);

    if ((APB_DATA_W < 8) || ((APB_DATA_W & (APB_DATA_W - 1)) != 0) ||
        ((APP_DATA_W % APB_DATA_W) != 0) || ((LANE_CNT & (LANE_CNT - 1)) != 0) ||
        (APP_ADDR_W > APB_ADDR_W) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("apb_mig_bridge: illegal parameter combination");
    end

    apb_mig_state_e            state_q, state_d;
    logic                      pready_q, pready_d;
    logic                      pslverr_q, pslverr_d;
    logic [APB_DATA_W-1:0]     prdata_q, prdata_d;
    logic [APP_ADDR_W-1:0]     app_addr_q, app_addr_d;
    logic [2:0]                app_cmd_q, app_cmd_d;
    logic                      app_en_q, app_en_d;
    logic                      wren_q, wren_d;
    logic [APP_DATA_W-1:0]     wdf_data_q, wdf_data_d;
    logic [APP_DATA_W/8-1:0]   wdf_mask_q, wdf_mask_d;
    logic                      cmd_done_q, cmd_done_d;
    logic                      data_done_q, data_done_d;
    logic [LANE_IDX_W-1:0]     rd_lane_q, rd_lane_d;

    logic                      req_err;
    logic [LANE_IDX_W-1:0]     lane;
    logic [APP_DATA_W-1:0]     pack_data;
    logic [APP_DATA_W/8-1:0]   pack_mask;
    logic [APB_DATA_W-1:0]     lane_rdata;

    // Misaligned word, address beyond the UI space, or DRAM not calibrated.
    assign req_err = ((paddr_i & APB_ADDR_W'(STRB_W - 1)) != '0) ||
                     ((paddr_i >> APP_ADDR_W) != '0) ||
                     !app_init_calib_complete_i;

    assign lane = (LANE_W > 0) ? LANE_IDX_W'(paddr_i >> OFF_W) : '0;

    apb_mig_lane_pack #(
        .APB_DATA_W (APB_DATA_W),
        .APP_DATA_W (APP_DATA_W),
        .LANE_IDX_W (LANE_IDX_W)
    ) u_lane_pack (
        .wdata_i      (pwdata_i),
        .wstrb_i      (pstrb_i),
        .wr_lane_i    (lane),
        .wide_data_o  (pack_data),
        .wide_mask_o  (pack_mask),
        .wide_rdata_i (app_rd_data_i),
        .rd_lane_i    (rd_lane_q),
        .rdata_o      (lane_rdata)
    );

`ifdef APB_MIG_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    always_comb begin
        state_d     = state_q;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        prdata_d    = prdata_q;
        app_addr_d  = app_addr_q;
        app_cmd_d   = app_cmd_q;
        app_en_d    = app_en_q;
        wren_d      = wren_q;
        wdf_data_d  = wdf_data_q;
        wdf_mask_d  = wdf_mask_q;
        cmd_done_d  = cmd_done_q;
        data_done_d = data_done_q;
        rd_lane_d   = rd_lane_q;

        unique case (state_q)
            IDLE: begin
                if (psel_i && penable_i) begin
                    if (req_err) begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else begin
                        app_addr_d  = paddr_i[APP_ADDR_W-1:0] & ~LOW_MASK;
                        rd_lane_d   = lane;
                        app_en_d    = 1'b1;
                        cmd_done_d  = 1'b0;
                        data_done_d = 1'b0;
                        if (pwrite_i) begin
                            state_d    = WRITE;
                            app_cmd_d  = APP_CMD_WRITE;
                            wren_d     = 1'b1;
                            wdf_data_d = pack_data;
                            wdf_mask_d = pack_mask;
                        end else begin
                            state_d   = RD_CMD;
                            app_cmd_d = APP_CMD_READ;
                        end
                    end
                end
            end
            // Command and data channels complete independently, in any order.
            WRITE: begin
                if (app_en_q && app_rdy_i) begin
                    app_en_d   = 1'b0;
                    cmd_done_d = 1'b1;
                end
                if (wren_q && app_wdf_rdy_i) begin
                    wren_d      = 1'b0;
                    data_done_d = 1'b1;
                end
                if (cmd_done_d && data_done_d) begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                end
            end
            RD_CMD: begin
                if (app_en_q && app_rdy_i) begin
                    app_en_d = 1'b0;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (app_rd_data_valid_i) begin
                    prdata_d = lane_rdata;
                    state_d  = RESP;
                    pready_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef APB_MIG_TIMEOUT_EN
        tmo_d = tmo_q;
        if (state_q == IDLE) begin
            tmo_d = '0;
        end else if (state_q == WRITE || state_q == RD_CMD || state_q == RD_WAIT) begin
            tmo_d = tmo_q + 1'b1;
            // A handshake completing on the final allowed cycle still wins.
            if (state_d != RESP && tmo_d == TMO_W'(TIMEOUT_CYCLES)) begin
                state_d   = RESP;
                pready_d  = 1'b1;
                pslverr_d = 1'b1;
                app_en_d  = 1'b0;
                wren_d    = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state_q     <= IDLE;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            prdata_q    <= '0;
            app_addr_q  <= '0;
            app_cmd_q   <= '0;
            app_en_q    <= 1'b0;
            wren_q      <= 1'b0;
            wdf_data_q  <= '0;
            wdf_mask_q  <= '0;
            cmd_done_q  <= 1'b0;
            data_done_q <= 1'b0;
            rd_lane_q   <= '0;
`ifdef APB_MIG_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            prdata_q    <= prdata_d;
            app_addr_q  <= app_addr_d;
            app_cmd_q   <= app_cmd_d;
            app_en_q    <= app_en_d;
            wren_q      <= wren_d;
            wdf_data_q  <= wdf_data_d;
            wdf_mask_q  <= wdf_mask_d;
            cmd_done_q  <= cmd_done_d;
            data_done_q <= data_done_d;
            rd_lane_q   <= rd_lane_d;
`ifdef APB_MIG_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign prdata_o       = prdata_q;
    assign pready_o       = pready_q;
    assign pslverr_o      = pslverr_q;
    assign app_addr_o     = app_addr_q;
    assign app_cmd_o      = app_cmd_q;
    assign app_en_o       = app_en_q;
    assign app_wdf_data_o = wdf_data_q;
    assign app_wdf_mask_o = wdf_mask_q;
    assign app_wdf_wren_o = wren_q;
    assign app_wdf_end_o  = wren_q;

endmodule

// File: tb/tb_apb_mig_bridge.sv
// tb_apb_mig_bridge: randomized APB traffic against a transaction-level model
// of the bridge, plus directed transfers with hand-computed expectations.
// Default parameters: 32-bit APB, 128-bit UI, 28-bit UI address.
module tb_apb_mig_bridge;

    logic         clk = 1'b0;
    logic         preset;
    logic [31:0]  paddr, pwdata;
    logic         pwrite, psel, penable;
    logic [3:0]   pstrb;
    logic [31:0]  prdata;
    logic         pready, pslverr;
    logic         calib;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy;
    logic [127:0] wdf_data;
    logic [15:0]  wdf_mask;
    logic         wdf_wren, wdf_end, wdf_rdy;
    logic [127:0] rd_data;
    logic         rd_valid;

    always #5 clk = ~clk;

    apb_mig_bridge dut (
        .pclk_i                    (clk),
        .preset_i                  (preset),
        .paddr_i                   (paddr),
        .pwdata_i                  (pwdata),
        .pwrite_i                  (pwrite),
        .psel_i                    (psel),
        .penable_i                 (penable),
        .pstrb_i                   (pstrb),
        .prdata_o                  (prdata),
        .pready_o                  (pready),
        .pslverr_o                 (pslverr),
        .app_init_calib_complete_i (calib),
        .app_addr_o                (app_addr),
        .app_cmd_o                 (app_cmd),
        .app_en_o                  (app_en),
        .app_rdy_i                 (app_rdy),
        .app_wdf_data_o            (wdf_data),
        .app_wdf_mask_o            (wdf_mask),
        .app_wdf_wren_o            (wdf_wren),
        .app_wdf_end_o             (wdf_end),
        .app_wdf_rdy_i             (wdf_rdy),
        .app_rd_data_i             (rd_data),
        .app_rd_data_valid_i       (rd_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // UI responder knobs
    int          rdy_pct = 100, wdf_pct = 100, vld_pct = 50, stray_pct = 0;
    int          hold_rdy_low = 0;
    int          fixed_dly = -1;
    logic        ovr_valid = 1'b0;
    logic        use_word  = 1'b0;
    logic [31:0] ovr_word  = '0;

    int en_cnt, wren_cnt;

    // Model: what the bridge owes the outside world for the current transfer.
    logic         m_busy = 0, m_is_wr = 0, m_rd_wait = 0;
    logic         m_en = 0, m_wren = 0, m_pready = 0, m_err = 0;
    logic [31:0]  m_prdata = '0;
    logic [27:0]  m_addr = '0;
    logic [2:0]   m_cmd = '0;
    logic [127:0] m_wdata = '0;
    logic [15:0]  m_wmask = '0;
    int           m_lane = 0, m_wait_cnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        logic cmd_hs, dat_hs;
        if (preset) begin
            m_busy = 0; m_is_wr = 0; m_rd_wait = 0; m_en = 0; m_wren = 0;
            m_pready = 0; m_err = 0; m_prdata = '0; m_addr = '0; m_cmd = '0;
            m_wdata = '0; m_wmask = '0;
            return;
        end
        cmd_hs = m_en && app_rdy;
        dat_hs = m_wren && wdf_rdy;
        if (m_pready) begin
            m_busy = 0; m_pready = 0; m_err = 0;
        end else if (!m_busy) begin
            if (psel && penable) begin
                if (paddr[1:0] != 2'b0 || paddr[31:28] != 4'h0 || !calib) begin
                    m_pready = 1; m_err = 1;
                end else begin
                    m_busy  = 1;
                    m_is_wr = pwrite;
                    m_lane  = int'(paddr[3:2]);
                    m_addr  = {paddr[27:4], 4'h0};
                    m_cmd   = pwrite ? 3'b000 : 3'b001;
                    m_en    = 1;
                    m_wren  = pwrite;
                    m_rd_wait = 0;
                    if (pwrite) begin
                        m_wdata = {4{pwdata}};
                        m_wmask = 16'hFFFF;
                        m_wmask[m_lane*4 +: 4] = ~pstrb;
                    end
                end
            end
        end else if (m_is_wr) begin
            if (cmd_hs) m_en = 0;
            if (dat_hs) m_wren = 0;
            if (!m_en && !m_wren) m_pready = 1;
        end else begin
            if (m_rd_wait) begin
                m_wait_cnt++;
                if (rd_valid) begin
                    m_prdata  = rd_data[m_lane*32 +: 32];
                    m_rd_wait = 0;
                    m_pready  = 1;
                end
            end else if (cmd_hs) begin
                m_en = 0; m_rd_wait = 1; m_wait_cnt = 0;
            end
        end
    endtask

    task automatic ui_drive();
        app_rdy = (hold_rdy_low > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
        if (hold_rdy_low > 0 && app_en) hold_rdy_low--;
        wdf_rdy = ($urandom_range(99) < wdf_pct);
        rd_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (ovr_valid) begin
            rd_valid = 1'b1;
            rd_data[95:64] = ovr_word;
            ovr_valid = 1'b0;
        end else if (m_rd_wait) begin
            rd_valid = (fixed_dly >= 0) ? (m_wait_cnt == fixed_dly)
                                        : ($urandom_range(99) < vld_pct);
            if (use_word) rd_data[95:64] = ovr_word;
        end else begin
            rd_valid = ($urandom_range(99) < stray_pct);
        end
    endtask

    task automatic compare();
        chk("pready", 128'(pready), 128'(m_pready));
        if (m_pready) chk("pslverr", 128'(pslverr), 128'(m_err));
        chk("prdata", 128'(prdata), 128'(m_prdata));
        chk("app_en", 128'(app_en), 128'(m_en));
        chk("wdf_wren", 128'(wdf_wren), 128'(m_wren));
        chk("wdf_end", 128'(wdf_end), 128'(m_wren));
        if (m_en) begin
            chk("app_addr", 128'(app_addr), 128'(m_addr));
            chk("app_cmd", 128'(app_cmd), 128'(m_cmd));
        end
        if (m_wren) begin
            chk("wdf_data", wdf_data, m_wdata);
            chk("wdf_mask", 128'(wdf_mask), 128'(m_wmask));
        end
    endtask

    // One clock: set UI inputs, advance the model over the edge, then compare.
    task automatic cycle();
        ui_drive();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare();
        en_cnt   += int'(app_en);
        wren_cnt += int'(wdf_wren);
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int acc, output logic err,
                            output logic [31:0] rd);
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        cycle();
        penable = 1; acc = 0; en_cnt = 0; wren_cnt = 0;
        do begin
            cycle();
            acc++;
        end while (!pready && acc < 200);
        chk("xfer_pready", 128'(pready), 128'(1));
        err = pslverr; rd = prdata;
        psel = 0; penable = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        logic        err;
        logic [31:0] rd;
        logic [31:0] a;

        preset = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        pstrb = '0; calib = 1; app_rdy = 0; wdf_rdy = 0; rd_data = '0; rd_valid = 0;
        en_cnt = 0; wren_cnt = 0;
        repeat (3) cycle();
        chk("rst_ctrl", 128'({pready, pslverr, app_en, wdf_wren, wdf_end, app_cmd}), 128'(0));
        chk("rst_prdata", 128'(prdata), 128'(0));
        chk("rst_addr", 128'(app_addr), 128'(0));
        chk("rst_wdata", wdf_data, 128'(0));
        chk("rst_mask", 128'(wdf_mask), 128'(0));
        preset = 0;
        cycle();

        // Directed write, UI always ready
        psel = 1; penable = 0; pwrite = 1; paddr = 32'h14; pwdata = 32'hDEADBEEF; pstrb = 4'hF;
        cycle();
        penable = 1;
        cycle();
        chk("wr_c2_en", 128'(app_en), 128'(1));
        chk("wr_c2_addr", 128'(app_addr), 128'(28'h10));
        chk("wr_c2_cmd", 128'(app_cmd), 128'(3'b000));
        chk("wr_c2_lane", 128'(wdf_data[63:32]), 128'(32'hDEADBEEF));
        chk("wr_c2_mask", 128'(wdf_mask), 128'(16'hFF0F));
        chk("wr_c2_end", 128'(wdf_end), 128'(1));
        chk("wr_c2_pready", 128'(pready), 128'(0));
        cycle();
        chk("wr_c3_pready", 128'(pready), 128'(1));
        chk("wr_c3_pslverr", 128'(pslverr), 128'(0));
        psel = 0; penable = 0;
        cycle();
        chk("wr_c4_pready", 128'(pready), 128'(0));

        // Directed read, data valid 5 cycles after the command
        fixed_dly = 4; use_word = 1; ovr_word = 32'h12345678;
        apb_xfer(1'b0, 32'h18, 32'h0, 4'h0, acc, err, rd);
        chk("rd_prdata", 128'(rd), 128'(32'h12345678));
        chk("rd_pslverr", 128'(err), 128'(0));
        chk("rd_latency", 128'(acc), 128'(7));
        cycle();
        chk("rd_pready_once", 128'(pready), 128'(0));
        chk("rd_prdata_hold", 128'(prdata), 128'(32'h12345678));
        use_word = 0;

        // Write with command channel stalled for 10 cycles
        hold_rdy_low = 10;
        apb_xfer(1'b1, 32'h24, 32'hA5A55A5A, 4'b0101, acc, err, rd);
        chk("stall_en_cycles", 128'(en_cnt), 128'(11));
        chk("stall_wren_cycles", 128'(wren_cnt), 128'(1));
        chk("stall_latency", 128'(acc), 128'(12));
        chk("stall_pslverr", 128'(err), 128'(0));

        // Error responses: misaligned, out of range, not calibrated
        apb_xfer(1'b1, 32'h2, 32'h1, 4'hF, acc, err, rd);
        chk("misalign_err", 128'({err, 8'(acc), 8'(en_cnt), 8'(wren_cnt)}), 128'({1'b1, 8'd1, 8'd0, 8'd0}));
        apb_xfer(1'b0, 32'h1000_0000, 32'h0, 4'h0, acc, err, rd);
        chk("range_err", 128'({err, 8'(acc), 8'(en_cnt), 8'(wren_cnt)}), 128'({1'b1, 8'd1, 8'd0, 8'd0}));
        calib = 0;
        apb_xfer(1'b1, 32'h40, 32'h1, 4'hF, acc, err, rd);
        chk("calib_err", 128'({err, 8'(acc), 8'(en_cnt), 8'(wren_cnt)}), 128'({1'b1, 8'd1, 8'd0, 8'd0}));
        calib = 1;

        // Reset while waiting for read data; the late data must be dropped
        fixed_dly = 1000;
        psel = 1; penable = 0; pwrite = 0; paddr = 32'h28;
        cycle();
        penable = 1;
        for (int i = 0; i < 10; i++) cycle();
        preset = 1; psel = 0; penable = 0;
        cycle();
        preset = 0;
        chk("mid_rst_ctrl", 128'({pready, pslverr, app_en, wdf_wren, wdf_end, app_cmd}), 128'(0));
        chk("mid_rst_prdata", 128'(prdata), 128'(0));
        chk("mid_rst_addr", 128'(app_addr), 128'(0));
        ovr_valid = 1; ovr_word = 32'hCAFEF00D;
        cycle();
        cycle();
        chk("late_data_prdata", 128'(prdata), 128'(0));
        chk("late_data_pready", 128'(pready), 128'(0));
        fixed_dly = 0; use_word = 1; ovr_word = 32'h600DF00D;
        apb_xfer(1'b0, 32'h18, 32'h0, 4'h0, acc, err, rd);
        chk("post_rst_rd", 128'({err, rd}), 128'({1'b0, 32'h600DF00D}));
        use_word = 0; fixed_dly = -1;

        // Randomized traffic, checked cycle by cycle against the model
        stray_pct = 10;
        for (int t = 0; t < 80; t++) begin
            int r;
            rdy_pct = $urandom_range(100, 20);
            wdf_pct = $urandom_range(100, 20);
            vld_pct = $urandom_range(100, 20);
            r = $urandom_range(99);
            a = ($urandom() & 32'h0FFF_FFF0) | (32'($urandom_range(3)) << 2);
            if (r < 8) a = a | 32'($urandom_range(3, 1));
            else if (r < 14) a = a | (32'h1000_0000 << $urandom_range(3));
            calib = ($urandom_range(99) >= 8);
            apb_xfer(1'($urandom_range(1)), a, $urandom(), 4'($urandom_range(15)), acc, err, rd);
            repeat ($urandom_range(2)) cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
